// File: rtl/div_16x8_seq.sv
// Sequential unsigned 16-by-8 restoring divider with valid/ready handshakes on both sides.
// STEPS_PER_CYCLE quotient bits are resolved per clock by a chained combinational step.
module div_16x8_seq #(
    parameter int unsigned STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  REM,
    output logic        ovf,
    output logic        dz
);

    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
          STEPS_PER_CYCLE == 4 || STEPS_PER_CYCLE == 8)) begin : g_bad_steps
        $error("div_16x8_seq: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [3:0] LastCnt = 4'(8 / STEPS_PER_CYCLE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  quo_q, quo_d;
    logic [7:0]  rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        dz_q, dz_d;

    logic [7:0]  r_step, q_step;
    logic [8:0]  t, diff;
    logic        qbit;

    // Restoring steps chained within one cycle; r < d keeps the remainder in 8 bits.
    always_comb begin
        r_step = r_q;
        q_step = q_q;
        t      = '0;
        diff   = '0;
        qbit   = 1'b0;
        for (int i = 0; i < int'(STEPS_PER_CYCLE); i++) begin
            t    = {r_step, q_step[7]};
            diff = t - {1'b0, d_q};
            if (t >= {1'b0, d_q}) begin
                r_step = diff[7:0];
                qbit   = 1'b1;
            end else begin
                r_step = t[7:0];
                qbit   = 1'b0;
            end
            q_step = {q_step[6:0], qbit};
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (B == 8'd0) begin
                        quo_d   = 8'hFF;
                        rem_d   = 8'hFF;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else if (A[15:8] >= B) begin
                        quo_d   = 8'hFF;
                        rem_d   = 8'h00;
                        ovf_d   = 1'b1;
                        dz_d    = 1'b0;
                        state_d = StDone;
                    end else begin
                        r_d     = A[15:8];
                        q_d     = A[7:0];
                        d_d     = B;
                        cnt_d   = 4'd0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LastCnt) begin
                    quo_d   = q_step;
                    rem_d   = r_step;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Q         = quo_q;
    assign REM       = rem_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: doc/div_16x8_seq.md
Name: div_16x8_seq

Overview:
- Sequential unsigned 16-by-8 restoring divider. It is the inverse-direction companion to the team's 8x8 multiplier datapath.
- Takes a 16-bit dividend (e.g. a product R) and an 8-bit divisor. Returns an 8-bit quotient and an 8-bit remainder, so multiplier outputs can be checked round-trip in error-characterization benches.
- Uses a valid/ready handshake on both the input side and the output side.
- Intended to share a clock domain with the multiplier blocks.

Parameters:
- STEPS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values: 1, 2, 4, 8. Any other value is a synthesis-time error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B are valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  16  dividend, unsigned.
- B  input  8  divisor, unsigned.
- out_valid  output  1  Q/REM/ovf/dz are valid.
- out_ready  input  1  consumer accepts the result.
- Q  output  8  quotient.
- REM  output  8  remainder.
- ovf  output  1  quotient does not fit in 8 bits.
- dz  output  1  divide by zero.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst has priority over every other event.
- Reset values:
  - state = IDLE
  - out_valid = 0
  - Q = 0, REM = 0, ovf = 0, dz = 0
  - in_ready = 1, since in_ready is decoded as state==IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - The accept edge is the first edge with in_valid=1 while in IDLE.
  - Exception checks at the accept edge, in priority order:
    - If B==0: Q=8'hFF, REM=8'hFF, dz=1, ovf=0, go to DONE.
    - Else if A[15:8] >= B: Q=8'hFF, REM=8'h00, ovf=1, dz=0, go to DONE.
    - Otherwise: load the 8-bit partial remainder r = A[15:8], the shift register q = A[7:0], and the divisor register d = B. Clear the step counter and go to RUN.
- RUN:
  - in_ready = 0. A and B are ignored; the operands are held internally.
  - Each edge performs STEPS_PER_CYCLE restoring steps, chained combinationally.
  - One restoring step:
    - t = {r, q[7]} (9 bits).
    - If t >= {1'b0, d}: r = t - d and bit = 1. Otherwise r = t[7:0] and bit = 0.
    - q = {q[6:0], bit}.
  - The invariant r < d guarantees that r always fits in 8 bits.
  - After 8/STEPS_PER_CYCLE RUN edges: Q = q, REM = r, ovf = 0, dz = 0, go to DONE.
- DONE:
  - out_valid = 1. Q, REM, ovf and dz are held stable while out_ready = 0, with no bound on the wait.
  - A transfer is an edge with out_valid=1 and out_ready=1. On a transfer, go to IDLE and clear out_valid.
  - Q, REM, ovf and dz keep their last values after the transfer.
  - in_ready is 0 in DONE. There is no same-cycle accept on transfer, so the next accept happens no earlier than the edge after returning to IDLE.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - Normal operation: 8/STEPS_PER_CYCLE + 1 edges (the load edge plus the RUN edges).
  - Exception (ovf or dz): 1 edge.
  - Throughput: at most one operation per latency + 1 cycles.
- Arithmetic identity: whenever ovf=0 and dz=0, A == Q*B + REM and REM < B.
- Boundary conditions:
  - A=0 with B≠0: normal path, Q=0, REM=0.
  - B=1 with A[15:8]≠0: ovf.
  - B=1 with A[15:8]=0: Q=A[7:0], REM=0.
  - in_valid asserted outside IDLE: ignored; no queuing.
  - out_ready asserted outside DONE: no effect.
  - rst during RUN or DONE: the operation is aborted, no out_valid pulse, and the block is in IDLE the next cycle.
- Step counter: a 4-bit width is sufficient. It wraps only through the reset or reload paths.

Test Plan:
- Normal division, STEPS_PER_CYCLE=1: A=16'd1000, B=8'd25, out_ready=1 -> Q=40, REM=0, ovf=0, dz=0. out_valid is first high 9 cycles after the accept edge and stays high for 1 cycle.
- Remainder and maximum non-overflow case: A=16'd4660, B=8'd86 -> Q=54, REM=16. A=16'hFEFF, B=8'hFF -> Q=255, REM=254. Repeat both with STEPS_PER_CYCLE=2, 4 and 8: same results, with latency 5, 3 and 2 respectively.
- Exceptions:
  - A=16'h1900, B=8'h19 -> ovf=1, Q=8'hFF, REM=0, out_valid 1 cycle after accept.
  - A=16'h1234, B=0 -> dz=1, Q=8'hFF, REM=8'hFF.
  - A=16'h1900, B=0 -> dz=1, ovf=0 (dz takes priority).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, Q and REM are held stable and in_ready=0. Toggle A, B and in_valid during that window -> ignored. Release out_ready -> the block returns to IDLE on the next edge.
- Reset mid-operation: assert rst for 1 cycle 3 cycles after accepting A=1000, B=25 -> no out_valid, and in_ready=1 on the cycle after rst. A new operation A=16'd255, B=8'd16 -> Q=15, REM=15.
- Randomized sweep of 10k random A/B pairs with random out_ready stalls. The scoreboard checks:
  - A == Q*B + REM and REM < B, or
  - correct ovf/dz flagging.
